countdown_ctrl: RTL
===================

// Module: countdown_ctrl
// PURPOSE
//  Sequencer for the countdown timer datapath. Turns debounced user button pulses into the
//  timer's command signals: target load, run/pause levels and clear. Owns the preset editor
//  (HH:MM:SS fields), the run/pause/ring state machine and the ring auto-silence timeout.
//  Sits between the debounced button block and the countdown timer; also drives the display mux.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; sets the 1 s prescaler terminal count
//  MAX_HOURS   35           hour field ceiling; 35:59:59 = 129599 fits 17 bits
//  RING_SEC    10           seconds of alarm before auto-silence
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-high
//  btn_set     in   1   one-cycle pulse: enter/leave edit, abort from PAUSE
//  btn_start   in   1   one-cycle pulse: start / pause / resume toggle
//  btn_next    in   1   one-cycle pulse: advance edit field SS->MM->HH->SS
//  btn_up      in   1   one-cycle pulse: increment selected field
//  btn_down    in   1   one-cycle pulse: decrement selected field
//  cd_done     in   1   timer buzzer output; one-cycle pulse at expiry
//  tar_sec     out  17  preset in seconds = hh*3600 + mm*60 + ss; registered
//  init_en     out  1   one-cycle load strobe to timer
//  run         out  1   level; 1 only in RUN
//  pause       out  1   level; 1 only in PAUSE
//  clear       out  1   one-cycle clear strobe to timer
//  edit_field  out  2   0=SS 1=MM 2=HH; 3 when not in EDIT
//  mode        out  3   current FSM state code
//  alarm_out   out  1   level; 1 only in RING
// BEHAVIOUR
//  Reset (async): state IDLE; hh=mm=ss=0; tar_sec=0; all strobes/levels 0; edit_field=3;
//   prescaler and ring counter 0. Reset mid-run aborts immediately; the timer sees run=0.
//  States: IDLE, EDIT, LOAD, RUN, PAUSE, RING.
//  - IDLE:  btn_set -> EDIT, with edit_field=SS. btn_start with tar_sec!=0 -> LOAD.
//           btn_start with tar_sec==0 is ignored.
//  - EDIT:  btn_next rotates the field. btn_up/btn_down wrap inside the field:
//           ss,mm in 0..59; hh in 0..MAX_HOURS.
//           btn_set -> IDLE. btn_start -> LOAD if tar_sec!=0, else ignored.
//  - LOAD:  init_en=1 for exactly this one cycle; unconditional -> RUN next cycle.
//  - RUN:   run=1. btn_start -> PAUSE. cd_done -> RING (cd_done wins over btn_start).
//  - PAUSE: pause=1, run=0. btn_start -> RUN. btn_set -> clear=1 for one cycle -> IDLE.
//  - RING:  alarm_out=1; prescaler counts seconds.
//           Any button, or RING_SEC elapsed -> clear=1 for one cycle -> IDLE.
//  Command-output timing:
//  - tar_sec updates the cycle after a field change; it is stable whenever init_en=1.
//  - run/pause/alarm_out/init_en/clear are registered: asserted the cycle after state entry.
//  - run and pause are never both 1; init_en and clear are never both 1.
//  Simultaneous button pulses:
//  - Priority: set > start > next > up > down; lower-priority pulses that cycle are dropped.
//  - Buttons other than those listed for a state are ignored.
//  Preset handling:
//  - The preset persists across runs; returning to IDLE does not zero hh/mm/ss.
//  - Prescaler: 0..CLK_HZ-1; runs only in RING and is zeroed on RING entry.
//  - Arithmetic: hh*3600 uses >=17-bit intermediates; there is no saturation (range is
//    guaranteed by MAX_HOURS).
// STRUCTURE
//  Shared package cd_ctrl_pkg:
//  - state encodings (IDLE=0 EDIT=1 LOAD=2 RUN=3 PAUSE=4 RING=5)
//  - field codes SS/MM/HH/NONE
//  - constants SEC_MAX=59, MIN_MAX=59
//  Sub-module hms_field_edit: holds hh/mm/ss, applies wrapping up/down to the selected
//  field, outputs registered tar_sec. FSM, prescaler and ring counter stay in countdown_ctrl.
// TESTING
//  1 Preset and load: reset; btn_set; 5x btn_up (SS=5); btn_next; 2x btn_up (MM=2); btn_start
//    -> tar_sec=125; init_en high exactly 1 cycle; run=1 from the next cycle.
//  2 Field wrap: in EDIT with SS=0, btn_down -> SS=59; HH=35, btn_up -> HH=0.
//    Also check 35:59:59 -> tar_sec=129599.
//  3 Zero preset: tar_sec=0; btn_start in IDLE and in EDIT -> no init_en, state unchanged.
//  4 Pause/resume: in RUN, btn_start -> pause=1, run=0; btn_start -> run=1.
//    btn_set in PAUSE -> clear 1 cycle, mode=IDLE, tar_sec retained.
//  5 Expiry: cd_done pulse in the same cycle as btn_start while in RUN -> RING, alarm_out=1.
//    With CLK_HZ=10, RING_SEC=3 -> clear after 30 cycles, then IDLE.
//    Repeat with btn_up during RING -> immediate clear, IDLE.
//  6 Async reset: assert rst mid-RUN between clock edges -> run=0, mode=IDLE, tar_sec=0
//    without waiting for a clock edge.

Source files
------------

// File: rtl/cd_ctrl_pkg.sv
// rtl/cd_ctrl_pkg.sv - shared state codes, field codes and preset arithmetic for countdown_ctrl
package cd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EDIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_RING  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FLD_SS   = 2'd0,
    FLD_MM   = 2'd1,
    FLD_HH   = 2'd2,
    FLD_NONE = 2'd3
  } field_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam int         TAR_W   = 17;

  function automatic logic [TAR_W-1:0] to_sec(input logic [TAR_W-1:0] hh,
                                              input logic [TAR_W-1:0] mm,
                                              input logic [TAR_W-1:0] ss);
    return hh * 17'd3600 + mm * 17'd60 + ss;
  endfunction

endpackage

// File: rtl/hms_field_edit.sv
// rtl/hms_field_edit.sv - hh/mm/ss preset registers with wrapping up/down edit and registered total seconds
module hms_field_edit
  import cd_ctrl_pkg::*;
#(
  parameter int MAX_HOURS = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  field_e           field,
  input  logic             inc,
  input  logic             dec,
  output logic [TAR_W-1:0] tar_sec
);

  localparam int HW = $clog2(MAX_HOURS + 1);

  logic [5:0]       ss_q, ss_d, mm_q, mm_d;
  logic [HW-1:0]    hh_q, hh_d;
  logic [TAR_W-1:0] tar_q, tar_d;

  always_comb begin
    ss_d = ss_q;
    mm_d = mm_q;
    hh_d = hh_q;
    if (inc || dec) begin
      case (field)
        FLD_SS: ss_d = inc ? ((ss_q == SEC_MAX) ? 6'd0 : ss_q + 6'd1)
                           : ((ss_q == 6'd0) ? SEC_MAX : ss_q - 6'd1);
        FLD_MM: mm_d = inc ? ((mm_q == MIN_MAX) ? 6'd0 : mm_q + 6'd1)
                           : ((mm_q == 6'd0) ? MIN_MAX : mm_q - 6'd1);
        FLD_HH: hh_d = inc ? ((hh_q == HW'(MAX_HOURS)) ? '0 : hh_q + HW'(1))
                           : ((hh_q == '0) ? HW'(MAX_HOURS) : hh_q - HW'(1));
        default: ;
      endcase
    end
    // Built from the next field values so the total is current one cycle after the button.
    tar_d = to_sec(TAR_W'(hh_d), TAR_W'(mm_d), TAR_W'(ss_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q  <= '0;
      mm_q  <= '0;
      hh_q  <= '0;
      tar_q <= '0;
    end else begin
      ss_q  <= ss_d;
      mm_q  <= mm_d;
      hh_q  <= hh_d;
      tar_q <= tar_d;
    end
  end

  assign tar_sec = tar_q;

endmodule

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - countdown timer sequencer: preset editor, run/pause/ring FSM, ring auto-silence
module countdown_ctrl
  import cd_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int MAX_HOURS = 35,
  parameter int RING_SEC  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_set,
  input  logic             btn_start,
  input  logic             btn_next,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             cd_done,
  output logic [TAR_W-1:0] tar_sec,
  output logic             init_en,
  output logic             run,
  output logic             pause,
  output logic             clear,
  output logic [1:0]       edit_field,
  output logic [2:0]       mode,
  output logic             alarm_out
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = $clog2(RING_SEC + 1);

  state_e        state_q, state_d;
  field_e        field_q, field_d, edit_field_q, edit_field_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] ring_q, ring_d;
  logic          run_q, run_d, pause_q, pause_d, alarm_q, alarm_d;
  logic          init_en_q, init_en_d, clear_q, clear_d;
  logic          inc, dec, tar_nz, any_btn, sec_tick, timeout;

  assign tar_nz   = (tar_sec != '0);
  assign any_btn  = btn_set | btn_start | btn_next | btn_up | btn_down;
  assign sec_tick = (presc_q == PW'(CLK_HZ - 1));
  assign timeout  = sec_tick && (ring_q == RW'(RING_SEC - 1));

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    presc_d = '0;
    ring_d  = '0;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_set) begin
          state_d = ST_EDIT;
          field_d = FLD_SS;
        end else if (btn_start && tar_nz) begin
          state_d = ST_LOAD;
        end
      end
      ST_EDIT: begin
        if (btn_set) begin
          state_d = ST_IDLE;
        end else if (btn_start) begin
          if (tar_nz) state_d = ST_LOAD;
        end else if (btn_next) begin
          case (field_q)
            FLD_SS:  field_d = FLD_MM;
            FLD_MM:  field_d = FLD_HH;
            default: field_d = FLD_SS;
          endcase
        end else if (btn_up) begin
          inc = 1'b1;
        end else if (btn_down) begin
          dec = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (cd_done)        state_d = ST_RING;
        else if (btn_start) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_set)        state_d = ST_IDLE;
        else if (btn_start) state_d = ST_RUN;
      end
      ST_RING: begin
        presc_d = sec_tick ? '0 : presc_q + PW'(1);
        ring_d  = sec_tick ? ring_q + RW'(1) : ring_q;
        if (any_btn || timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Counters only live inside RING, so leaving it (or entering it) starts them from zero.
    if (state_d != ST_RING || state_q != ST_RING) begin
      presc_d = '0;
      ring_d  = '0;
    end
    run_d        = (state_d == ST_RUN);
    pause_d      = (state_d == ST_PAUSE);
    alarm_d      = (state_d == ST_RING);
    init_en_d    = (state_d == ST_LOAD);
    clear_d      = (state_d == ST_IDLE) && (state_q == ST_PAUSE || state_q == ST_RING);
    edit_field_d = (state_d == ST_EDIT) ? field_d : FLD_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      field_q      <= FLD_SS;
      edit_field_q <= FLD_NONE;
      presc_q      <= '0;
      ring_q       <= '0;
      run_q        <= 1'b0;
      pause_q      <= 1'b0;
      alarm_q      <= 1'b0;
      init_en_q    <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      edit_field_q <= edit_field_d;
      presc_q      <= presc_d;
      ring_q       <= ring_d;
      run_q        <= run_d;
      pause_q      <= pause_d;
      alarm_q      <= alarm_d;
      init_en_q    <= init_en_d;
      clear_q      <= clear_d;
    end
  end

  hms_field_edit #(
    .MAX_HOURS(MAX_HOURS)
  ) u_fields (
    .clk    (clk),
    .rst    (rst),
    .field  (field_q),
    .inc    (inc),
    .dec    (dec),
    .tar_sec(tar_sec)
  );

  assign init_en    = init_en_q;
  assign run        = run_q;
  assign pause      = pause_q;
  assign clear      = clear_q;
  assign alarm_out  = alarm_q;
  assign edit_field = edit_field_q;
  assign mode       = state_q;

endmodule
